// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/load-store memory port arbiter: FSM state encoding and owner IDs.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_pick2.sv
// Combinational 2-way winner select for mem_port_arbiter.
// Fixed LSU priority by default; MEM_ARB_ROUND_ROBIN_EN alternates on contention using last_owner_i.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic ifu_valid_i,
  input  logic lsu_valid_i,
  input  logic last_owner_i,
  output logic grant_o,
  output logic owner_o
);

  always_comb begin
    grant_o = ifu_valid_i | lsu_valid_i;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (ifu_valid_i && lsu_valid_i) owner_o = ~last_owner_i;
    else                            owner_o = lsu_valid_i ? OWN_LSU : OWN_IFU;
`else
    // The older instruction owns the LSU request, so it wins outright.
    owner_o = lsu_valid_i ? OWN_LSU : OWN_IFU;
`endif
  end

`ifndef MEM_ARB_ROUND_ROBIN_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner_i;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between fetch (IFU) and load/store (LSU), one transaction at a time.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN adds a last_owner flop for alternating grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rsp_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rsp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_rdata,
  output logic                busy
);

  localparam int MASK_W = DATA_W / 8;

  arb_state_e          state_q, state_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic                pick_grant, pick_owner, last_owner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;
  assign last_owner = last_owner_q;
`else
  assign last_owner = OWN_IFU;
`endif

  arb_pick2 u_pick (
    .ifu_valid_i  (ifu_req_valid),
    .lsu_valid_i  (lsu_req_valid),
    .last_owner_i (last_owner),
    .grant_o      (pick_grant),
    .owner_o      (pick_owner)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d       = state_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    wen_d         = wen_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_rdata = '0;
    lsu_rsp_valid = 1'b0;
    lsu_rsp_rdata = '0;
    mem_req_valid = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_owner_d  = last_owner_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_grant) begin
          owner_d = pick_owner;
          state_d = ARB_REQ;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_owner_d = pick_owner;
`endif
          if (pick_owner == OWN_LSU) begin
            lsu_req_ready = 1'b1;
            addr_d        = lsu_req_addr;
            wen_d         = lsu_req_wen;
            wdata_d       = lsu_req_wdata;
            wmask_d       = lsu_req_wmask;
          end else begin
            // Fetches are always reads: store fields are forced clear.
            ifu_req_ready = 1'b1;
            addr_d        = ifu_req_addr;
            wen_d         = 1'b0;
            wdata_d       = '0;
            wmask_d       = '0;
          end
        end
      end
      ARB_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (mem_rsp_valid) begin
          state_d = ARB_IDLE;
          if (owner_q == OWN_LSU) begin
            lsu_rsp_valid = 1'b1;
            lsu_rsp_rdata = mem_rsp_rdata;
          end else begin
            ifu_rsp_valid = 1'b1;
            ifu_rsp_rdata = mem_rsp_rdata;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_owner_q <= OWN_IFU;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;
  assign busy          = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (both default and MEM_ARB_ROUND_ROBIN_EN builds).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_req_addr, ifu_rsp_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_rdata;
  logic [3:0]  lsu_req_wmask;
  logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid, busy;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;
  logic [3:0]  mem_req_wmask;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_rdata(ifu_rsp_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are read 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Called in WAIT: pulses the memory response, checks routing, then checks the pulse ends cleanly.
  task automatic rsp_now(input string tag, input logic own_lsu, input logic [31:0] rd);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = rd;
    #1;
    chk({tag, "_ifu_rsp_v"}, ifu_rsp_valid, !own_lsu);
    chk({tag, "_lsu_rsp_v"}, lsu_rsp_valid, own_lsu);
    chk({tag, "_rsp_rdata"}, own_lsu ? lsu_rsp_rdata : ifu_rsp_rdata, rd);
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'h0;
    #1;
    chk({tag, "_no_dup_ifu"}, ifu_rsp_valid, 1'b0);
    chk({tag, "_no_dup_lsu"}, lsu_rsp_valid, 1'b0);
    chk({tag, "_stale_rdata"}, {ifu_rsp_rdata, lsu_rsp_rdata}, 64'h0);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic        exp_lsu, own;
    logic [31:0] a, rd;
    int          w;

    // Reset state
    rst_n = 1'b0;
    ifu_req_valid = 0; ifu_req_addr = 0;
    lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wmask = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;
    #3;
    chk("rst_valids", {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid}, 5'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fields", {mem_req_addr, mem_req_wen, mem_req_wmask}, 37'h0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    #1;
    chk("idle_after_rst", {busy, mem_req_valid}, 2'b00);

    // Lone IFU fetch, zero-wait memory
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000; mem_req_ready = 1;
    #1;
    chk("ifu_ready_N", {ifu_req_ready, lsu_req_ready}, 2'b10);
    tick();
    ifu_req_valid = 0;
    #1;
    chk("ifu_memv_N1", mem_req_valid, 1'b1);
    chk("ifu_addr_N1", mem_req_addr, 32'h8000_0000);
    chk("ifu_wen_mask", {mem_req_wen, mem_req_wmask}, 5'h0);
    chk("ifu_ready_drop", ifu_req_ready, 1'b0);
    tick();
    chk("ifu_wait_memv", mem_req_valid, 1'b0);
    rsp_now("ifu_N2", 1'b0, 32'h0000_0413);

    // Contention: LSU store against IFU fetch
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0004;
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_1000; lsu_req_wen = 1;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'hF;
    #1;
    chk("cont1_ready", {ifu_req_ready, lsu_req_ready}, 2'b01);
    tick();
    lsu_req_addr = 32'h8000_2000; lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wmask = 0;
    #1;
    chk("cont1_store", {mem_req_addr, mem_req_wdata}, {32'h8000_1000, 32'hDEAD_BEEF});
    chk("cont1_wen_mask", {mem_req_wen, mem_req_wmask}, 5'h1F);
    chk("cont1_loser_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
    tick();
    rsp_now("cont1_rsp", 1'b1, 32'h0000_0001);

    // Second contention: fixed priority repeats LSU, round-robin hands it to IFU
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_lsu = 1'b0;
`else
    exp_lsu = 1'b1;
`endif
    chk("cont2_ready", {ifu_req_ready, lsu_req_ready}, {!exp_lsu, exp_lsu});
    tick();
    if (exp_lsu) lsu_req_valid = 0; else ifu_req_valid = 0;
    #1;
    chk("cont2_addr", mem_req_addr, exp_lsu ? 32'h8000_2000 : 32'h8000_0004);
    chk("cont2_wen", mem_req_wen, 1'b0);
    tick();
    rsp_now("cont2_rsp", exp_lsu, 32'h2222_0002);
    chk("loser_ready", {ifu_req_ready, lsu_req_ready}, {exp_lsu, !exp_lsu});

    // Backpressure: loser accepted, then memory stalls 5 cycles with both requesters waiting
    mem_req_ready = 0;
    tick();
    a = exp_lsu ? 32'h8000_0004 : 32'h8000_2000;
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0008;
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_3000; lsu_req_wen = 1;
    lsu_req_wdata = 32'h1234_5678; lsu_req_wmask = 4'h3;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_addr_%0d", c), mem_req_addr, a);
      chk($sformatf("bp_v_rdy_%0d", c), {mem_req_valid, ifu_req_ready, lsu_req_ready}, 3'b100);
      tick();
    end
    mem_req_ready = 1;
    #1;
    chk("bp_c6_valid", {mem_req_valid, mem_req_wen, mem_req_wdata}, {2'b10, 32'h0});
    tick();
    mem_req_ready = 0;
    ifu_req_valid = 0; lsu_req_valid = 0; lsu_req_wen = 0; lsu_req_wmask = 0;
    #1;
    chk("bp_in_wait", {busy, mem_req_valid}, 2'b10);
    rsp_now("bp_rsp", !exp_lsu, 32'h3333_0003);

    // Stray response in IDLE
    mem_rsp_valid = 1; mem_rsp_rdata = 32'hBAD0_0BAD;
    #1;
    chk("stray_idle_rsp", {ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_rdata, lsu_rsp_rdata}, 66'h0);
    tick();
    mem_rsp_valid = 0;
    #1;
    chk("stray_idle_state", busy, 1'b0);

    // Reset while in WAIT, late response must be dropped
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_000C; mem_req_ready = 1;
    tick();
    ifu_req_valid = 0;
    tick();
    #1;
    chk("rstw_in_wait", {busy, mem_req_valid}, 2'b10);
    rst_n = 0;
    #1;
    chk("rstw_idle_now", {busy, mem_req_valid, mem_req_addr}, 34'h0);
    tick();
    rst_n = 1;
    mem_rsp_valid = 1; mem_rsp_rdata = 32'h0BAD_CAFE;
    #1;
    chk("rstw_late_drop", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
    tick();
    mem_rsp_valid = 0;
    #1;
    chk("rstw_state", busy, 1'b0);

    // Back-to-back alternating loads with random wait states
    for (int i = 0; i < 8; i++) begin
      own = i[0];
      a   = 32'h8000_0100 + 32'(i * 4);
      rd  = 32'hA5A5_0000 + 32'(i);
      mem_req_ready = 0;
      if (own) begin
        lsu_req_valid = 1; lsu_req_addr = a; lsu_req_wen = 0;
      end else begin
        ifu_req_valid = 1; ifu_req_addr = a;
      end
      #1;
      chk($sformatf("b2b%0d_ready", i), {ifu_req_ready, lsu_req_ready}, {!own, own});
      tick();
      ifu_req_valid = 0; lsu_req_valid = 0;
      w = $urandom_range(0, 3);
      repeat (w) tick();
      mem_req_ready = 1;
      #1;
      chk($sformatf("b2b%0d_req", i), {mem_req_valid, mem_req_addr}, {1'b1, a});
      tick();
      mem_req_ready = 0;
      w = $urandom_range(0, 3);
      repeat (w) begin
        #1;
        chk($sformatf("b2b%0d_early", i), {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
        tick();
      end
      rsp_now($sformatf("b2b%0d", i), own, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
